regfile_wr_arbiter: RTL
=======================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL expose: clk  in  1  write-side clock; all state updates on rising edge.
REQ-002 SHALL expose: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL expose: clr  in  1  request soft clear of r1..r31.
REQ-004 SHALL expose: a_valid  in  1  requester A (ALU write-back) has a write.
REQ-005 SHALL expose: a_addr  in  5  A destination register.
REQ-006 SHALL expose: a_data  in  32  A write data.
REQ-007 SHALL expose: a_ready  out  1  A write accepted this cycle when a_valid is also high.
REQ-008 SHALL expose: b_valid, b_addr (5), b_data (32) in, and b_ready (1) out, for requester B (load write-back), with the same meanings.
REQ-009 SHALL expose: wt_addr  out  5  register-file write address.
REQ-010 SHALL expose: wt_data  out  32  register-file write data.
REQ-011 SHALL expose: L_S  out  1  register-file write enable.
REQ-012 SHALL expose: busy  out  1  soft clear in progress.

Function
REQ-013 SHALL implement two states, IDLE and CLEAR, a 5-bit clear counter cnt, and a 1-bit round-robin priority register prio (0=A, 1=B).
REQ-014 SHALL compute the grant combinationally in IDLE with clr low:
- only A valid: grant A
- only B valid: grant B
- both valid: grant the requester selected by prio
REQ-015 SHALL drive a_ready/b_ready high only for the granted requester, only in IDLE with clr low; both ready outputs are low in CLEAR and in any cycle where clr is high.
REQ-016 SHALL, on each rising edge with an accepted request (valid&ready), register wt_addr<=addr and wt_data<=data, and set L_S<=1 if addr!=0 or L_S<=0 if addr==0; the transfer is complete on that edge and latency is one cycle.
REQ-017 SHALL drive L_S low on the rising edge following any IDLE cycle with no accepted request, holding wt_addr/wt_data at their previous values.
REQ-018 SHALL set prio to B after a grant to A and to A after a grant to B, and hold prio when there is no grant.
REQ-019 SHALL register outputs (1, 0, L_S=1), set cnt<=2 and enter CLEAR on a rising edge in IDLE with clr high; clr takes precedence over any valid request in that cycle, and nothing is accepted.
REQ-020 SHALL, on each rising edge in CLEAR, register outputs (cnt, 0, L_S=1), then return to IDLE if cnt==31, otherwise increment cnt.
- Result: addresses 1..31 written with zero on 31 consecutive cycles.
REQ-021 SHALL ignore clr while in CLEAR; no re-trigger or extension occurs.
REQ-022 SHALL drive busy high exactly while in CLEAR.
- busy is low in the clr-sampling cycle and high for the following 30 cycles.
REQ-023 SHALL leave prio unchanged across a clear sequence.
REQ-024 SHALL never produce L_S=1 with wt_addr==0.

Reset
REQ-025 SHALL, while rst is high, asynchronously force:
- state IDLE, cnt 0, prio A
- wt_addr 0, wt_data 0, L_S 0
- busy 0, a_ready 0, b_ready 0
REQ-026 SHALL abort a clear sequence on rst without completing the remaining writes; after release, the block accepts requests on the first edge with valid high.

Verification
REQ-027 Single write: a_valid=1, a_addr=5, a_data=0xDEADBEEF for one cycle -> a_ready=1; next cycle wt_addr=5, wt_data=0xDEADBEEF, L_S=1; the following cycle L_S=0.
REQ-028 Contention: A and B both held valid for 4 cycles from reset -> grants A, B, A, B; ready is never high on both in one cycle; output writes alternate between A and B data.
REQ-029 x0 write: b_valid=1, b_addr=0, b_data=0x1234 -> b_ready=1; next cycle L_S=0.
REQ-030 Soft clear: clr pulse while a_valid=1 -> a_ready=0 for 31 cycles; L_S=1 with wt_addr 1..31 and wt_data=0 on 31 consecutive cycles; busy high for 30 cycles; A accepted on the cycle after wt_addr=31.
REQ-031 Reset mid-clear: assert rst when wt_addr=10 in CLEAR -> L_S=0 and busy=0 immediately; after release, no further clear writes occur.
REQ-032 Clear/priority interaction: grant A, then clr, then A and B both valid after the clear completes -> B is granted first.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - two-requester register-file write arbiter with round-robin priority and soft clear of r1..r31
module regfile_wr_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic [4:0]  wt_addr,
    output logic [31:0] wt_data,
    output logic        L_S,
    output logic        busy
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic        prio_q;
    logic [4:0]  wt_addr_q;
    logic [31:0] wt_data_q;
    logic        ls_q;

    logic can_grant;
    logic grant_a;
    logic grant_b;

    // clr beats any pending request; rst gates ready so it is low for the whole reset
    always_comb begin
        can_grant = (state_q == IDLE) && !clr && !rst;
        grant_a   = can_grant && a_valid && (!b_valid || !prio_q);
        grant_b   = can_grant && b_valid && (!a_valid || prio_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            prio_q    <= 1'b0;
            wt_addr_q <= 5'd0;
            wt_data_q <= 32'd0;
            ls_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr) begin
                        wt_addr_q <= 5'd1;
                        wt_data_q <= 32'd0;
                        ls_q      <= 1'b1;
                        cnt_q     <= 5'd2;
                        state_q   <= CLEAR;
                    end else if (grant_a) begin
                        wt_addr_q <= a_addr;
                        wt_data_q <= a_data;
                        ls_q      <= (a_addr != 5'd0);
                        prio_q    <= 1'b1;
                    end else if (grant_b) begin
                        wt_addr_q <= b_addr;
                        wt_data_q <= b_data;
                        ls_q      <= (b_addr != 5'd0);
                        prio_q    <= 1'b0;
                    end else begin
                        ls_q      <= 1'b0;
                    end
                end
                CLEAR: begin
                    // clr is deliberately ignored here: one sweep of r1..r31 per trigger
                    wt_addr_q <= cnt_q;
                    wt_data_q <= 32'd0;
                    ls_q      <= 1'b1;
                    if (cnt_q == 5'd31) begin
                        cnt_q   <= 5'd0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= cnt_q + 5'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;
    assign wt_addr = wt_addr_q;
    assign wt_data = wt_data_q;
    assign L_S     = ls_q;
    assign busy    = (state_q == CLEAR);

endmodule
